slink_fifo_wr_arb: RTL and testbench
====================================

Name: slink_fifo_wr_arb

Overview:
Round-robin write-side arbiter that shares one slink async FIFO write port among NUM_REQ requesters in the wclk domain.
- Grants are packet-locked: a winner owns the FIFO until its beat flagged last is accepted.
- Gates new grants on FIFO almost_full and honours wfull beat-by-beat.
- Reports the current owner and a saturating stall counter for debug.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
REQ_IDX_W, 2, width of requester index; must equal clog2(NUM_REQ)
DATA_SIZE, 40, FIFO data width; matches FIFO DATA_SIZE
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  write-side clock (FIFO wclk)
reset_n  in  1  asynchronous, active-low reset
enable  in  1  allow new grants; does not abort a burst in progress
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last-beat-of-packet flag
req_data  in  NUM_REQ*DATA_SIZE  packed beat data; requester i at [i*DATA_SIZE +: DATA_SIZE]
req_ready  out  NUM_REQ  beat accepted when req_valid[i] & req_ready[i]
fifo_wfull  in  1  FIFO full flag
fifo_almost_full  in  1  FIFO almost_full flag
fifo_winc  out  1  FIFO write increment
fifo_wdata  out  DATA_SIZE  FIFO write data
grant_active  out  1  a burst owns the FIFO
grant_id  out  REQ_IDX_W  current/last owner index
stall_cnt  out  STALL_CNT_W  cycles with grant_active & fifo_wfull, saturating
stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- States IDLE, BURST. Reset to IDLE.
- Reset values: grant_active=0, grant_id=NUM_REQ-1 (so requester 0 wins first), stall_cnt=0, req_ready=0, fifo_winc=0, fifo_wdata=0.
- IDLE, arbitration:
  - Condition: enable & |req_valid & ~fifo_almost_full & ~fifo_wfull.
  - Winner is the first valid index searching upward from grant_id+1, modulo NUM_REQ.
  - Registered result: grant_id<=winner, grant_active<=1, next state BURST.
  - Arbitration latency is 1 cycle: no beat is accepted in the IDLE cycle.
- BURST, data phase (combinational from the registered grant):
  - req_ready[grant_id] = ~fifo_wfull; all other req_ready = 0.
  - fifo_winc = req_valid[grant_id] & ~fifo_wfull.
  - fifo_wdata = req_data slice of grant_id when grant_active, else 0.
- BURST exit: when an accepted beat carries req_last[grant_id], go to IDLE and clear grant_active. grant_id holds as the RR pointer.
- One-cycle IDLE gap between bursts is required; back-to-back bursts occur no faster than every (beats+1) cycles.
- Owner drops req_valid mid-burst: stay in BURST with no writes. Other requesters are not granted.
- fifo_wfull in BURST: no write, stall_cnt increments (saturates at all-ones), burst resumes when wfull clears.
- fifo_almost_full affects only new grants; an in-progress burst continues to wfull.
- enable deasserted mid-burst: burst completes normally, then no new grant.
- stall_clr has priority over increment; stall_cnt <= 0.
- Single-beat packet (valid & last on first BURST cycle, not full): one write, back to IDLE next cycle.
- Reset asserted mid-burst: all state returns to reset values immediately. A partial packet may be left in the FIFO; the upper layer flushes it by resetting the FIFO.
- Requester set with only grant_id valid: that requester is re-granted (RR wraps to itself).

Decomposition:
- Shared package slink_fifo_arb_pkg: state encoding (IDLE=1'b0, BURST=1'b1) and the REQ_IDX_W derivation helper.
- One sub-module, slink_rr_arbiter:
  - Inputs: req vector, pointer.
  - Outputs: winner index and any_valid, combinational, using a mask/double-vector scheme.
- Parent owns the FSM, data mux and stall counter.

Test Plan:
- Reset, all four requesters present 1-beat packets continuously → grants in order 0,1,2,3,0; exactly one fifo_winc per 2 cycles; fifo_wdata equals each requester's data.
- Req1 sends a 5-beat packet while req0/req2 are valid → req1 owns 5 accepted beats with no interleave; next grant is 2.
- fifo_wfull forced high for 7 cycles mid-burst → no winc, req_ready low, stall_cnt=7; burst resumes; stall_clr then gives stall_cnt=0.
- fifo_almost_full high in IDLE with req0 valid → no grant. Raised mid-burst → burst completes all beats.
- enable dropped on the 2nd beat of a 4-beat burst → 4 beats written, grant_active falls, no further grants while req valid.
- reset_n pulsed low on beat 3 of a burst → outputs at reset values asynchronously; after release req0 wins first.

Source files
------------

// File: rtl/slink_fifo_arb_pkg.sv
// Shared definitions for the slink FIFO write-side arbiter: FSM encoding and
// the requester-index width helper.
package slink_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Smallest index width able to address n requesters (at least 1 bit).
  function automatic int req_idx_w(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/slink_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// ptr+1, wrapping modulo NUM_REQ, using a doubled request vector.
module slink_rr_arbiter
  import slink_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = req_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [REQ_IDX_W-1:0] winner,
  output logic                 any_valid
);

  localparam int SUM_W = REQ_IDX_W + 2;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SUM_W-1:0]     start;
  logic [SUM_W-1:0]     sum;
  logic [REQ_IDX_W-1:0] offset;

  // Rotating the doubled vector puts ptr+1 at bit 0, so the lowest set bit
  // of rot is the round-robin distance to the winner.
  assign dbl   = {req, req};
  assign start = SUM_W'(ptr) + SUM_W'(1);
  assign rot   = NUM_REQ'(dbl >> start);

  always_comb begin
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = REQ_IDX_W'(i);
    end
  end

  assign sum       = start + SUM_W'(offset);
  assign winner    = REQ_IDX_W'((sum >= SUM_W'(NUM_REQ)) ? sum - SUM_W'(NUM_REQ) : sum);
  assign any_valid = |req;

endmodule

// File: rtl/slink_fifo_wr_arb.sv
// Packet-locked round-robin arbiter sharing one slink async FIFO write port
// among NUM_REQ requesters, with a saturating full-stall debug counter.
module slink_fifo_wr_arb
  import slink_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_IDX_W   = req_idx_w(NUM_REQ),
  parameter int DATA_SIZE   = 40,
  parameter int STALL_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_wfull,
  input  logic                         fifo_almost_full,
  output logic                         fifo_winc,
  output logic [DATA_SIZE-1:0]         fifo_wdata,
  output logic                         grant_active,
  output logic [REQ_IDX_W-1:0]         grant_id,
  output logic [STALL_CNT_W-1:0]       stall_cnt,
  input  logic                         stall_clr
);

  arb_state_e             state_reg, state_next;
  logic [REQ_IDX_W-1:0]   grant_id_reg, grant_id_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  logic [REQ_IDX_W-1:0]   winner;
  logic                   any_valid;
  logic                   start_grant;
  logic [DATA_SIZE-1:0]   data_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_slice[gi] = req_data[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  slink_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (grant_id_reg),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // almost_full only blocks new ownership; an owned burst runs until wfull.
  assign start_grant = enable & any_valid & ~fifo_almost_full & ~fifo_wfull;

  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    req_ready     = '0;
    fifo_winc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_grant) begin
          grant_id_next = winner;
          state_next    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id_reg] = ~fifo_wfull;
        fifo_winc               = req_valid[grant_id_reg] & ~fifo_wfull;
        if (fifo_winc && req_last[grant_id_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_active = (state_reg == BURST);
  assign grant_id     = grant_id_reg;
  assign stall_cnt    = stall_cnt_reg;
  assign fifo_wdata   = grant_active ? data_slice[grant_id_reg] : '0;

  // grant_id doubles as the round-robin pointer, so it holds after a burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_id_reg  <= REQ_IDX_W'(NUM_REQ - 1);
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      if (stall_clr) begin
        stall_cnt_reg <= '0;
      end else if (grant_active && fifo_wfull && !(&stall_cnt_reg)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slink_fifo_wr_arb.sv
// Scoreboard bench for slink_fifo_wr_arb: queued requester sources, expected
// beats pushed at stimulus time and popped on each fifo_winc.
module tb_slink_fifo_wr_arb;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 40;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wfull = 1'b0;
  logic            fifo_almost_full = 1'b0;
  logic            fifo_winc;
  logic [DW-1:0]   fifo_wdata;
  logic            grant_active;
  logic [IW-1:0]   grant_id;
  logic [SW-1:0]   stall_cnt;
  logic            stall_clr = 1'b0;

  always #5 clk = ~clk;

  slink_fifo_wr_arb #(
    .NUM_REQ(N), .REQ_IDX_W(IW), .DATA_SIZE(DW), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_wfull(fifo_wfull),
    .fifo_almost_full(fifo_almost_full), .fifo_winc(fifo_winc),
    .fifo_wdata(fifo_wdata), .grant_active(grant_active),
    .grant_id(grant_id), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; } exp_t;

  beat_t        src_q [N][$];
  exp_t         exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           wr_cnt = 0;
  int           wr_cyc [int];
  logic [N-1:0] acc = '0;
  int           base;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int id, input int pkt, input int beat);
    return {8'(id), 8'(pkt), 24'(beat)};
  endfunction

  task automatic push_pkt(input int id, input int pkt, input int nbeats);
    beat_t bt;
    exp_t  e;
    for (int b = 0; b < nbeats; b++) begin
      bt.last = (b == nbeats - 1);
      bt.data = mk_data(id, pkt, b);
      src_q[id].push_back(bt);
      e.id   = IW'(id);
      e.data = bt.data;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int k = 0;
    while (wr_cnt < target && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(wr_cnt >= target), 1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_active"}, grant_active, 0);
    check_eq({tag, "_grant_id"}, grant_id, N - 1);
    check_eq({tag, "_stall"}, stall_cnt, 0);
    check_eq({tag, "_ready"}, req_ready, 0);
    check_eq({tag, "_winc"}, fifo_winc, 0);
    check_eq({tag, "_wdata"}, fifo_wdata, 0);
  endtask

  always @(posedge clk) cyc++;

  // Requester sources: retire accepted heads, then present the next beat.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_last[i]            = src_q[i][0].last;
        req_data[i*DW +: DW]   = src_q[i][0].data;
      end else begin
        req_valid[i]           = 1'b0;
        req_last[i]            = 1'b0;
        req_data[i*DW +: DW]   = '0;
      end
    end
  end

  // Write monitor: one line per accepted FIFO write.
  always @(negedge clk) begin
    exp_t e;
    acc = req_valid & req_ready;
    if (fifo_winc) begin
      wr_cnt++;
      wr_cyc[wr_cnt] = cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_winc", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("write %0d: id=%0d data=0x%0h cyc=%0d", wr_cnt, grant_id, fifo_wdata, cyc);
        check_eq("wdata", fifo_wdata, e.data);
        check_eq("wid", grant_id, e.id);
        check_eq("ready_onehot", req_ready, N'(1) << e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    tick();
    reset_n = 1'b1;
    enable  = 1'b1;

    // Round robin with single-beat packets from every requester.
    base = wr_cnt;
    for (int p = 0; p < 2; p++)
      for (int id = 0; id < N; id++) push_pkt(id, p, 1);
    drain("rr_drain");
    for (int k = 2; k <= 8; k++)
      check_eq("rr_spacing", wr_cyc[base+k] - wr_cyc[base+k-1], 2);

    // Multi-beat packet is not interleaved; pointer then moves to 2.
    push_pkt(0, 10, 1);
    drain("pre_burst_drain");
    push_pkt(1, 11, 5);
    push_pkt(2, 12, 1);
    push_pkt(0, 13, 1);
    drain("burst_drain");

    // wfull mid-burst stalls for exactly 7 cycles.
    base = wr_cnt;
    push_pkt(3, 20, 6);
    wait_writes(base + 2, "full_pre_writes");
    fifo_wfull = 1'b1;
    repeat (7) begin
      @(negedge clk);
      check_eq("full_ready", req_ready, 0);
      check_eq("full_winc", fifo_winc, 0);
      tick();
    end
    fifo_wfull = 1'b0;
    @(negedge clk);
    check_eq("stall_cnt", stall_cnt, 7);
    drain("full_drain");
    tick();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    @(negedge clk);
    check_eq("stall_clr", stall_cnt, 0);

    // almost_full blocks a grant in IDLE but not an owned burst.
    fifo_almost_full = 1'b1;
    push_pkt(0, 30, 3);
    repeat (5) begin
      @(negedge clk);
      check_eq("af_no_grant", grant_active, 0);
      check_eq("af_no_winc", fifo_winc, 0);
      tick();
    end
    base = wr_cnt;
    fifo_almost_full = 1'b0;
    wait_writes(base + 1, "af_first_write");
    fifo_almost_full = 1'b1;
    drain("af_drain");
    fifo_almost_full = 1'b0;

    // enable dropped on beat 2: burst completes, no new grant follows.
    base = wr_cnt;
    push_pkt(1, 40, 4);
    push_pkt(2, 41, 1);
    wait_writes(base + 1, "en_first_write");
    enable = 1'b0;
    wait_writes(base + 4, "en_burst_done");
    repeat (6) begin
      @(negedge clk);
      check_eq("en_no_grant", grant_active, 0);
      check_eq("en_no_winc", fifo_winc, 0);
      tick();
    end
    check_eq("en_held_req", src_q[2].size(), 1);
    check_eq("en_write_count", wr_cnt - base, 4);
    enable = 1'b1;
    drain("en_drain");

    // Asynchronous reset on beat 3; requester 0 wins first afterwards.
    base = wr_cnt;
    push_pkt(3, 50, 5);
    wait_writes(base + 2, "rst_pre_writes");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_q.delete();
    src_q[3].delete();
    tick();
    tick();
    reset_n = 1'b1;
    push_pkt(0, 52, 1);
    push_pkt(1, 51, 1);
    drain("post_rst_drain");

    // Only the current owner valid: it is granted again.
    push_pkt(1, 60, 1);
    push_pkt(1, 61, 1);
    drain("self_drain");
    check_eq("self_regrant_id", grant_id, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
